seq_shifter: RTL and testbench

- Parametrised, multi-cycle successor to the 8-bit single-step shift unit in the multicycle datapath.
- Shifts or rotates a WIDTH-bit operand by a run-time amount, one bit position per clock.
- Uses a start/busy/done handshake so the multicycle controller can sequence it like other iterative units.
- Holds the result stable until the next accepted start.

---
 rtl/shift_pkg.sv | 16 +
 rtl/shift_step.sv | 45 ++++
 rtl/seq_shifter.sv | 113 +++++++++++
 tb/tb_seq_shifter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - control codes and FSM state encoding shared by the sequential shifter
package shift_pkg;

    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_ROR = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational one-position shift/rotate step
// Reserved codes pass the operand through and report a zero shifted-out bit.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] operand_i,
    input  logic [2:0]       control_i,
    output logic [WIDTH-1:0] result_o,
    output logic             shout_o
);

    always_comb begin
        result_o = operand_i;
        shout_o  = 1'b0;
        case (control_i)
            OP_ROL: begin
                result_o = {operand_i[WIDTH-2:0], operand_i[WIDTH-1]};
                shout_o  = operand_i[WIDTH-1];
            end
            OP_ROR: begin
                result_o = {operand_i[0], operand_i[WIDTH-1:1]};
                shout_o  = operand_i[0];
            end
            OP_SLL: begin
                result_o = {operand_i[WIDTH-2:0], 1'b0};
                shout_o  = operand_i[WIDTH-1];
            end
            OP_SRA: begin
                result_o = {operand_i[WIDTH-1], operand_i[WIDTH-1:1]};
                shout_o  = operand_i[0];
            end
            OP_SRL: begin
                result_o = {1'b0, operand_i[WIDTH-1:1]};
                shout_o  = operand_i[0];
            end
            default: begin
                result_o = operand_i;
                shout_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle shifter, one bit position per clock, start/busy/done handshake
// Optional carry/zero flag outputs are enabled by defining SEQ_SHIFTER_FLAGS_EN.
module seq_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       control,
    input  logic [AMT_W-1:0] amount,
    output logic [WIDTH-1:0] out,
    output logic             busy,
`ifdef SEQ_SHIFTER_FLAGS_EN
    output logic             carry,
    output logic             zero,
`endif
    output logic             done
);

    state_t           state_q;
    logic [WIDTH-1:0] out_q;
    logic [AMT_W-1:0] count_q;
    logic [2:0]       ctrl_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] step_val;
    logic             step_bit;

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .operand_i(out_q),
        .control_i(ctrl_q),
        .result_o (step_val),
        .shout_o  (step_bit)
    );

`ifdef SEQ_SHIFTER_FLAGS_EN
    logic carry_q;
    logic zero_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if ((state_q != ST_SHIFT) && start) begin
            carry_q <= 1'b0;
            zero_q  <= (data == '0);
        end else if ((state_q == ST_SHIFT) && (count_q != '0)) begin
            carry_q <= step_bit;
            zero_q  <= (step_val == '0);
        end
    end

    assign carry = carry_q;
    assign zero  = zero_q;
`else
    logic unused_step_bit;
    assign unused_step_bit = step_bit;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            count_q <= '0;
            ctrl_q  <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        out_q   <= data;
                        ctrl_q  <= control;
                        count_q <= amount;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    // The zero-count edge only retires the op, so latency is amount+1 edges.
                    if (count_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        out_q   <= step_val;
                        count_q <= count_q - AMT_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - randomized self-checking bench for seq_shifter against an arithmetic model
module tb_seq_shifter;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] data;
    logic [2:0] control;
    logic [2:0] amount;
    logic [7:0] out;
    logic       busy;
    logic       done;
`ifdef SEQ_SHIFTER_FLAGS_EN
    logic       carry;
    logic       zero;
`endif

    int n_checks = 0;
    int n_errors = 0;

    seq_shifter #(.WIDTH(8), .AMT_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .data   (data),
        .control(control),
        .amount (amount),
        .out    (out),
        .busy   (busy),
`ifdef SEQ_SHIFTER_FLAGS_EN
        .carry  (carry),
        .zero   (zero),
`endif
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Whole-operation model: {last bit shifted out, result}.
    function automatic logic [8:0] ref_op(input logic [2:0] op, input logic [7:0] x, input int n);
        int               v;
        logic [7:0]       r;
        logic             c;
        logic signed [7:0] s;
        v = x;
        r = x;
        c = 1'b0;
        if (n != 0) begin
            case (op)
                3'd0: begin r = 8'(((v << n) | (v >> (8 - n))) & 255); c = x[8-n]; end
                3'd1: begin r = 8'(((v >> n) | (v << (8 - n))) & 255); c = x[n-1]; end
                3'd2: begin r = 8'((v << n) & 255); c = x[8-n]; end
                3'd3: begin s = x; s = s >>> n; r = s; c = x[n-1]; end
                3'd4: begin r = 8'(v >> n); c = x[n-1]; end
                default: begin r = x; c = 1'b0; end
            endcase
        end
        return {c, r};
    endfunction

    task automatic scramble_inputs();
        start   = 1'b0;
        data    = 8'($urandom);
        control = 3'($urandom);
        amount  = 3'($urandom);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [7:0] d, input int n, input string tag);
        int         lat;
        int         busy_n;
        logic [8:0] exp;
        exp = ref_op(op, d, n);
        @(negedge clk);
        start = 1'b1; data = d; control = op; amount = 3'(n);
        @(posedge clk); #1;
        scramble_inputs();
        lat = 0;
        busy_n = 0;
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, n + 1);
        check({tag, " busy_cycles"}, busy_n, n + 1);
        check({tag, " out"}, {24'd0, out}, {24'd0, exp[7:0]});
`ifdef SEQ_SHIFTER_FLAGS_EN
        check({tag, " carry"}, {31'd0, carry}, {31'd0, exp[8]});
        check({tag, " zero"}, {31'd0, zero}, {31'd0, (exp[7:0] == 8'd0)});
`endif
        @(posedge clk); #1;
        check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, " out_hold"}, {24'd0, out}, {24'd0, exp[7:0]});
    endtask

    initial begin
        int k;
        int seen_done;
        rst = 1'b1;
        start = 1'b0; data = '0; control = '0; amount = '0;
        #3;
        check("reset out", {24'd0, out}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(3'b000, 8'h81, 1, "rol81x1");
        run_op(3'b011, 8'h80, 3, "sra80x3");
        run_op(3'b100, 8'h80, 3, "srl80x3");
        run_op(3'b001, 8'h01, 7, "ror01x7");
        run_op(3'b010, 8'hFF, 0, "sllFFx0");
        run_op(3'b101, 8'h5A, 4, "rsv5Ax4");
        run_op(3'b010, 8'h80, 1, "sll80x1");
        run_op(3'b001, 8'h02, 2, "ror02x2");
        run_op(3'b000, 8'h3C, 0, "rol3Cx0");

        // start during SHIFT is dropped; start in the DONE cycle is accepted
        @(negedge clk);
        start = 1'b1; data = 8'h01; control = 3'b010; amount = 3'd5;
        @(posedge clk); #1;
        scramble_inputs();
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b1; data = 8'hF0; control = 3'b100; amount = 3'd2;
        @(posedge clk); #1;
        scramble_inputs();
        k = 2;
        while (!done && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check("ignored latency", k, 6);
        check("ignored out", {24'd0, out}, 32'h20);
        start = 1'b1; data = 8'h80; control = 3'b000; amount = 3'd1;
        @(posedge clk); #1;
        scramble_inputs();
        check("b2b busy", {31'd0, busy}, 32'd1);
        k = 0;
        while (!done && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check("b2b latency", k, 2);
        check("b2b out", {24'd0, out}, 32'h01);

        // asynchronous reset in the middle of SHIFT
        @(negedge clk);
        start = 1'b1; data = 8'hFF; control = 3'b100; amount = 3'd6;
        @(posedge clk); #1;
        scramble_inputs();
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async rst out", {24'd0, out}, 32'd0);
        check("async rst busy", {31'd0, busy}, 32'd0);
        seen_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("no done after rst", seen_done, 0);
        run_op(3'b011, 8'h96, 5, "post_rst");

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 7), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
